// File: rtl/tx_eq_tap_search_pkg.sv
// tx_eq_tap_search_pkg: shared TX-EQ types and constants for the tap search controller
package tx_eq_tap_search_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, APPLY, DONE} tap_search_state_e;
  localparam int TAP_WIDTH_DEF = 4;
  typedef logic [TAP_WIDTH_DEF-1:0] tap_code_t;
  localparam real OPENING_INIT = -1.0;
endpackage

// File: rtl/tx_eq_tap_search_if.sv
// tx_eq_tap_search_if: measurement in, equalizer code and search status out
interface tx_eq_tap_search_if #(parameter int TAP_WIDTH = 4);
  logic                 start;
  real                  opening;
  logic                 opening_ready;
  logic [TAP_WIDTH-1:0] tap_code;
  logic                 busy;
  logic                 done;
  real                  best_opening;
  modport master (output start, opening, opening_ready, input tap_code, busy, done, best_opening);
  modport slave  (input start, opening, opening_ready, output tap_code, busy, done, best_opening);
endinterface

// File: rtl/tx_eq_tap_search.sv
// tx_eq_tap_search: sweeps the FFE code, averages eye openings per code, applies the best code
module tx_eq_tap_search
  import tx_eq_tap_search_pkg::*;
#(
  parameter int TAP_WIDTH      = 4,
  parameter int TAP_MAX        = 15,
  parameter int DEFAULT_CODE   = 0,
  parameter int SETTLE_WINDOWS = 1,
  parameter int AVG_WINDOWS    = 2
) (
  input logic clock,
  input logic reset,
  tx_eq_tap_search_if.slave bus
);
  tap_search_state_e    state_q, state_d;
  logic [TAP_WIDTH-1:0] tap_code_q, tap_code_d, best_code_q, best_code_d;
  logic                 busy_q, busy_d, done_q, done_d;
  real                  best_opening_q, best_opening_d, best_val_q, best_val_d, acc_q, acc_d, avg;
  logic [15:0]          cnt_q, cnt_d;
  logic                 last_settle, last_avg;
  tap_search_state_e    after_code;
  assign last_settle = cnt_q == 16'(SETTLE_WINDOWS - 1);
  assign last_avg    = cnt_q == 16'(AVG_WINDOWS - 1);
  assign after_code  = SETTLE_WINDOWS == 0 ? MEASURE : SETTLE;
  assign bus.tap_code     = tap_code_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.best_opening = best_opening_q;
  // next-state: settle windows are counted and discarded, measure windows are accumulated
  always_comb begin
    state_d        = state_q;
    tap_code_d     = tap_code_q;
    best_code_d    = best_code_q;
    busy_d         = busy_q;
    done_d         = done_q;
    best_opening_d = best_opening_q;
    best_val_d     = best_val_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    avg            = (acc_q + bus.opening) / real'(AVG_WINDOWS);
    unique case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d    = after_code;
        tap_code_d = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        best_val_d = OPENING_INIT;
        acc_d      = 0.0;
        cnt_d      = '0;
      end
      SETTLE: if (bus.opening_ready) begin
        state_d = last_settle ? MEASURE : SETTLE;
        cnt_d   = last_settle ? '0 : cnt_q + 16'd1;
      end
      MEASURE: if (bus.opening_ready) begin
        if (last_avg) begin
          if (avg > best_val_q) begin
            best_val_d  = avg;
            best_code_d = tap_code_q;
          end
          acc_d      = 0.0;
          cnt_d      = '0;
          state_d    = tap_code_q == TAP_WIDTH'(TAP_MAX) ? APPLY : after_code;
          tap_code_d = tap_code_q == TAP_WIDTH'(TAP_MAX) ? tap_code_q : tap_code_q + 1'b1;
        end else begin
          acc_d = acc_q + bus.opening;
          cnt_d = cnt_q + 16'd1;
        end
      end
      APPLY: begin
        state_d        = DONE;
        tap_code_d     = best_code_q;
        best_opening_d = best_val_q;
        busy_d         = 1'b0;
        done_d         = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any search in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      tap_code_q     <= TAP_WIDTH'(DEFAULT_CODE);
      best_code_q    <= TAP_WIDTH'(DEFAULT_CODE);
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      best_opening_q <= 0.0;
      best_val_q     <= OPENING_INIT;
      acc_q          <= 0.0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      tap_code_q     <= tap_code_d;
      best_code_q    <= best_code_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      best_opening_q <= best_opening_d;
      best_val_q     <= best_val_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tx_eq_tap_search.sv
// tb_tx_eq_tap_search: randomized sweeps checked against a per-code averaging model via a scoreboard
module tb_tx_eq_tap_search;
  localparam int SW = 1, AW = 2, TM = 15, DC = 3;
  typedef struct {int code; real best;} exp_t;
  logic clock = 0, reset = 0;
  int checks = 0, failures = 0, cyc = 0, last_set = 0;
  logic done_prev = 0;
  exp_t sb[$];
  exp_t mon_e;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  tx_eq_tap_search_if #(.TAP_WIDTH(4)) bus();
  tx_eq_tap_search #(.TAP_WIDTH(4), .TAP_MAX(TM), .DEFAULT_CODE(DC), .SETTLE_WINDOWS(SW), .AVG_WINDOWS(AW))
    dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_real(string name, real act, real exp);
    checks++;
    if (act - exp > 1e-9 || exp - act > 1e-9) begin
      failures++;
      $display("FAIL %s actual=%f required=%f", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(real v);
    bus.opening = v;
    bus.opening_ready = 1;
    last_set = cyc;
    tick();
    bus.opening_ready = 0;
    repeat ($urandom_range(1, 4)) tick();
  endtask

  task automatic do_start(bit coinc);
    bus.start = 1;
    bus.opening_ready = coinc;
    bus.opening = 5.0;
    tick();
    bus.start = 0;
    bus.opening_ready = 0;
    chk_int("start_busy", int'(bus.busy), 1);
    chk_int("start_code", int'(bus.tap_code), 0);
    chk_int("start_done", int'(bus.done), 0);
  endtask

  // mode 0: peaked profile around peak, 1: flat 0.4, 2: random dyadic samples (ties likely)
  task automatic run(int mode, int peak, int abort_code, bit mid_start, bit coinc);
    real s[16][2];
    real best, sum;
    int bc;
    for (int c = 0; c <= TM; c++)
      for (int i = 0; i < AW; i++)
        s[c][i] = mode == 0 ? 1.0 - 0.05 * real'(c > peak ? c - peak : peak - c) :
                  mode == 1 ? 0.4 : real'($urandom_range(0, 8)) * 0.125 - 0.25;
    best = -1.0;
    bc = DC;
    for (int c = 0; c <= TM; c++) begin
      sum = 0.0;
      for (int i = 0; i < AW; i++) sum = sum + s[c][i];
      sum = sum / real'(AW);
      if (sum > best) begin
        best = sum;
        bc = c;
      end
    end
    do_start(coinc);
    sb.push_back('{bc, best});
    for (int c = 0; c <= TM; c++) begin
      chk_int("sweep_code", int'(bus.tap_code), c);
      chk_int("sweep_busy", int'(bus.busy), 1);
      for (int i = 0; i < SW; i++) strobe(2.0 + real'($urandom_range(0, 3)) * 0.5);
      if (mid_start && c == 9) begin
        bus.start = 1;
        tick();
        bus.start = 0;
        chk_int("ignored_start_code", int'(bus.tap_code), 9);
      end
      for (int i = 0; i < AW; i++) begin
        strobe(s[c][i]);
        if (c == abort_code && i == 0) begin
          reset = 0;
          #1;
          chk_int("abort_code", int'(bus.tap_code), DC);
          chk_int("abort_busy", int'(bus.busy), 0);
          chk_int("abort_done", int'(bus.done), 0);
          chk_real("abort_best", bus.best_opening, 0.0);
          void'(sb.pop_back());
          tick();
          reset = 1;
          tick();
          return;
        end
      end
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending required=done");
      sb.delete();
    end
    strobe(3.0);
    chk_int("hold_code", int'(bus.tap_code), bc);
    chk_int("hold_done", int'(bus.done), 1);
    chk_real("hold_best", bus.best_opening, best);
  endtask

  // monitor: every rising done is matched against the oldest expected search result
  always @(negedge clock) begin
    if (bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        chk_int("final_code", int'(bus.tap_code), mon_e.code);
        chk_real("final_best", bus.best_opening, mon_e.best);
        chk_int("done_latency", cyc, last_set + 2);
        chk_int("final_busy", int'(bus.busy), 0);
      end
    end
    done_prev <= bus.done;
  end

  initial begin
    bus.start = 0;
    bus.opening_ready = 0;
    bus.opening = 0.0;
    repeat (3) tick();
    chk_int("rst_code", int'(bus.tap_code), DC);
    chk_int("rst_busy", int'(bus.busy), 0);
    chk_int("rst_done", int'(bus.done), 0);
    chk_real("rst_best", bus.best_opening, 0.0);
    reset = 1;
    tick();
    strobe(0.7);
    chk_int("idle_code", int'(bus.tap_code), DC);
    chk_int("idle_busy", int'(bus.busy), 0);
    run(0, 6, -1, 0, 0);
    run(1, 0, -1, 0, 1);
    repeat (3) run(2, 0, -1, 0, 1'($urandom_range(0, 1)));
    run(0, $urandom_range(0, TM), -1, 1, 0);
    run(0, 6, 5, 0, 0);
    run(0, 6, -1, 0, 0);
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
